timer_ctl_multi: RTL and testbench
==================================

# timer_ctl_multi

Parametrised control FSM for the timer datapath, successor to the two-field (min/sec) controller. Sequences a configurable number of editable fields through init, setup, run and pause. Edge-detects the trig/set buttons internally and optionally generates auto-repeat inc/dec pulses while up/down are held. Sits between the debounced board buttons and the counter/register datapath.

## Interface
- NUM_FIELDS, 2: number of editable fields; must be ≥ 2. Field NUM_FIELDS-1 is most significant (gen-1 "min").
- FSEL_W, $clog2(NUM_FIELDS): width of field_sel; derived, not overridden.
- RPT_DELAY, 50: cycles up/down must be held before the first repeat pulse.
- RPT_PERIOD, 10: cycles between repeat pulses after RPT_DELAY.
- RPT_W, 16: width of the repeat counter; must hold max(RPT_DELAY, RPT_PERIOD).
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trig  in  1  start/pause button, debounced level.
- set  in  1  field-select button, debounced level.
- up  in  1  increment request, level.
- down  in  1  decrement request, level.
- complete  in  1  datapath reached terminal count, level.
- init_regs  out  1  load datapath registers with initial value.
- count_enabled  out  1  datapath counts.
- inc  out  1  increment the selected field.
- dec  out  1  decrement the selected field.
- field_sel  out  FSEL_W  index of the field being edited.
- done  out  1  one-cycle pulse when a run completes.
- state  out  3  current FSM state encoding, for debug/LEDs.

## Operation
- trig_ev = trig & ~trig_q; set_ev = set & ~set_q (trig_q/set_q are registered previous samples).
- States (3-bit): S_INIT=0, S_SETUP=1, S_RUN=2, S_PAUSE=3; other codes go to S_INIT.
- S_INIT: init_regs=1. set_ev → S_SETUP with field_sel=NUM_FIELDS-1. trig_ev → S_RUN.
- S_SETUP: inc/dec active. set_ev → field_sel-1, wrapping 0 → NUM_FIELDS-1. trig_ev → S_RUN.
- S_RUN: count_enabled=1. complete → S_INIT with done=1 for one cycle. trig_ev → S_PAUSE.
- S_PAUSE: all outputs idle. trig_ev → S_RUN. set_ev → S_SETUP with field_sel=NUM_FIELDS-1. complete → S_INIT without done.
- Priority within one cycle: complete > trig_ev > set_ev.
- inc/dec are forced to 0 outside S_SETUP. up & down together → both 0, and the repeat counter clears.
- field_sel holds its value outside S_SETUP, except where a transition above reloads it.
- init_regs, count_enabled and state are Moore decodes of the state register.

## Timing
- Reset values: state=S_INIT, init_regs=1, count_enabled=0, inc=0, dec=0, field_sel=NUM_FIELDS-1, done=0, trig_q=0, set_q=0, repeat counter=0.
- Asserting reset_n low aborts any state immediately; outputs return to reset values asynchronously.
- A button event takes effect at the first rising edge at which the button is sampled high. Its outputs are valid from that edge.
- A held trig/set produces exactly one event. Release and re-press is required for another.
- done is registered and high for the cycle following the S_RUN → S_INIT edge.

## Configuration
- CTL_AUTOREPEAT_EN defined:
  - inc/dec are registered one-cycle pulses.
  - One pulse on the first edge up (or down) is sampled high in S_SETUP.
  - Further pulses after RPT_DELAY cycles of continuous hold, then every RPT_PERIOD cycles.
  - Release, direction change or leaving S_SETUP clears the counter.
- CTL_AUTOREPEAT_EN undefined:
  - inc = up & ~down & (state==S_SETUP); dec likewise.
  - Both are combinational levels, compatible with gen-1 behaviour.
  - RPT_* parameters are ignored; no repeat logic is synthesised.

## Structure
- Shared package timer_ctl_pkg holds:
  - the state typedef/localparams (S_INIT..S_PAUSE);
  - STATE_W=3;
  - default RPT_DELAY/RPT_PERIOD constants.
- Sub-module rpt_gen (one instance per direction, only under CTL_AUTOREPEAT_EN):
  - inputs: clk, reset_n, enable, level;
  - output: pulse;
  - parameters: RPT_DELAY, RPT_PERIOD, RPT_W.

## Test plan
- Reset then release → init_regs=1, count_enabled=0, inc=dec=0, field_sel=1 (NUM_FIELDS=2), state=0.
- NUM_FIELDS=3: three set presses from S_INIT → field_sel 2,1,0; a fourth press wraps to 2. Holding set 5 cycles counts as one event.
- In S_SETUP, hold up 80 cycles with RPT_DELAY=50, RPT_PERIOD=10 (macro on):
  - inc pulses at cycles 0, 50, 60, 70; exactly 4 pulses.
  - up & down together → no pulses.
- trig from S_SETUP → S_RUN (count_enabled=1, inc=dec=0); trig → S_PAUSE (count_enabled=0); trig → S_RUN; complete → S_INIT, init_regs=1, done pulse of 1 cycle.
- Same cycle complete=1 and trig rising in S_RUN → S_INIT (complete wins). reset_n low mid-S_RUN → all outputs at reset values before the next edge.
- Macro off: up=1 in S_SETUP → inc=1 combinationally for the whole hold; up=1 in S_RUN → inc=0.

Source files
------------

// File: rtl/timer_ctl_pkg.sv
// Shared types and defaults for the multi-field timer control FSM.
package timer_ctl_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned RPT_DELAY_DEF  = 50;
  localparam int unsigned RPT_PERIOD_DEF = 10;

  typedef enum logic [STATE_W-1:0] {
    S_INIT  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3
  } state_e;

endpackage

// File: rtl/rpt_gen.sv
// Auto-repeat pulse generator: one pulse when level is first seen, then after RPT_DELAY
// cycles of continuous hold, then every RPT_PERIOD cycles.
module rpt_gen
  import timer_ctl_pkg::*;
#(
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF,
  parameter int unsigned RPT_W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic level_i,
  output logic pulse_o
);

  logic [RPT_W-1:0] cnt_d, cnt_q;
  logic             rep_d, rep_q;
  logic             pulse_d, pulse_q;

  // rep_q selects which interval cnt_q is timing: initial delay or repeat period.
  always_comb begin
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    pulse_d = 1'b0;
    if (!(enable_i && level_i)) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (!rep_q && cnt_q == '0) begin
      pulse_d = 1'b1;
      cnt_d   = RPT_W'(1);
    end else if ((!rep_q && cnt_q == RPT_W'(RPT_DELAY)) ||
                 (rep_q && cnt_q == RPT_W'(RPT_PERIOD))) begin
      pulse_d = 1'b1;
      cnt_d   = RPT_W'(1);
      rep_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + RPT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/timer_ctl_multi.sv
// Multi-field timer control FSM (init/setup/run/pause) with button edge detection.
// Define CTL_AUTOREPEAT_EN for registered auto-repeat inc/dec pulses; else inc/dec are levels.
module timer_ctl_multi
  import timer_ctl_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 2,
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF,
  parameter int unsigned RPT_W      = 16,
  localparam int unsigned FSEL_W    = $clog2(NUM_FIELDS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               trig_i,
  input  logic               set_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               complete_i,
  output logic               init_regs_o,
  output logic               count_enabled_o,
  output logic               inc_o,
  output logic               dec_o,
  output logic [FSEL_W-1:0]  field_sel_o,
  output logic               done_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [FSEL_W-1:0] FselTop = FSEL_W'(NUM_FIELDS - 1);

  state_e            state_d, state_q;
  logic [FSEL_W-1:0] fsel_d, fsel_q;
  logic              trig_q, set_q;
  logic              done_d, done_q;
  logic              trig_ev, set_ev, in_setup;

  assign trig_ev  = trig_i & ~trig_q;
  assign set_ev   = set_i & ~set_q;
  assign in_setup = (state_q == S_SETUP);

  // Priority inside each state: complete > trig_ev > set_ev.
  always_comb begin
    state_d = state_q;
    fsel_d  = fsel_q;
    done_d  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (trig_ev) begin
          state_d = S_RUN;
        end else if (set_ev) begin
          state_d = S_SETUP;
          fsel_d  = FselTop;
        end
      end
      S_SETUP: begin
        if (trig_ev) begin
          state_d = S_RUN;
        end else if (set_ev) begin
          fsel_d = (fsel_q == '0) ? FselTop : fsel_q - FSEL_W'(1);
        end
      end
      S_RUN: begin
        if (complete_i) begin
          state_d = S_INIT;
          done_d  = 1'b1;
        end else if (trig_ev) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (complete_i) begin
          state_d = S_INIT;
        end else if (trig_ev) begin
          state_d = S_RUN;
        end else if (set_ev) begin
          state_d = S_SETUP;
          fsel_d  = FselTop;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      fsel_q  <= FselTop;
      trig_q  <= 1'b0;
      set_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fsel_q  <= fsel_d;
      trig_q  <= trig_i;
      set_q   <= set_i;
      done_q  <= done_d;
    end
  end

  assign init_regs_o     = (state_q == S_INIT);
  assign count_enabled_o = (state_q == S_RUN);
  assign field_sel_o     = fsel_q;
  assign done_o          = done_q;
  assign state_o         = state_q;

`ifdef CTL_AUTOREPEAT_EN
  logic inc_pulse, dec_pulse;

  rpt_gen #(
    .RPT_DELAY  (RPT_DELAY),
    .RPT_PERIOD (RPT_PERIOD),
    .RPT_W      (RPT_W)
  ) u_rpt_inc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (in_setup),
    .level_i  (up_i & ~down_i),
    .pulse_o  (inc_pulse)
  );

  rpt_gen #(
    .RPT_DELAY  (RPT_DELAY),
    .RPT_PERIOD (RPT_PERIOD),
    .RPT_W      (RPT_W)
  ) u_rpt_dec (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (in_setup),
    .level_i  (down_i & ~up_i),
    .pulse_o  (dec_pulse)
  );

  // A pulse registered on the edge that leaves S_SETUP must not leak out.
  assign inc_o = inc_pulse & in_setup;
  assign dec_o = dec_pulse & in_setup;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{RPT_DELAY, RPT_PERIOD, RPT_W};

  assign inc_o = up_i & ~down_i & in_setup;
  assign dec_o = down_i & ~up_i & in_setup;
`endif

endmodule

// File: tb/tb_timer_ctl_multi.sv
// Self-checking bench for timer_ctl_multi: vector table, corner-case sequences and random
// stimulus against a behavioural model. Two instances (3 and 2 fields) share the inputs.
module tb_timer_ctl_multi;

  localparam int D = 50;
  localparam int P = 10;
  localparam int StInit  = 0;
  localparam int StSetup = 1;
  localparam int StRun   = 2;
  localparam int StPause = 3;

  logic clk, rst_n;
  logic trig, set, up, down, complete;

  logic       init3, cnt3, inc3, dec3, done3;
  logic [1:0] fsel3;
  logic [2:0] st3;
  logic       init2, cnt2, inc2, dec2, done2;
  logic [0:0] fsel2;
  logic [2:0] st2;

  timer_ctl_multi #(
    .NUM_FIELDS (3),
    .RPT_DELAY  (D),
    .RPT_PERIOD (P),
    .RPT_W      (16)
  ) u_dut3 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .trig_i          (trig),
    .set_i           (set),
    .up_i            (up),
    .down_i          (down),
    .complete_i      (complete),
    .init_regs_o     (init3),
    .count_enabled_o (cnt3),
    .inc_o           (inc3),
    .dec_o           (dec3),
    .field_sel_o     (fsel3),
    .done_o          (done3),
    .state_o         (st3)
  );

  timer_ctl_multi #(
    .NUM_FIELDS (2),
    .RPT_DELAY  (D),
    .RPT_PERIOD (P),
    .RPT_W      (16)
  ) u_dut2 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .trig_i          (trig),
    .set_i           (set),
    .up_i            (up),
    .down_i          (down),
    .complete_i      (complete),
    .init_regs_o     (init2),
    .count_enabled_o (cnt2),
    .inc_o           (inc2),
    .dec_o           (dec2),
    .field_sel_o     (fsel2),
    .done_o          (done2),
    .state_o         (st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model. State transitions are independent of the field count.
  int m_st;
  int m_fsel[2];
  int nf[2] = '{3, 2};
  bit m_tp, m_sp, m_done, m_inc, m_dec;
  int m_ku, m_kd;  // hold index of up/down in setup, -1 when not holding

  function automatic bit rpt_hit(input int k);
    return (k == 0) || (k >= D && ((k - D) % P) == 0);
  endfunction

  task automatic model_reset();
    m_st = StInit;
    for (int i = 0; i < 2; i++) m_fsel[i] = nf[i] - 1;
    m_tp = 0; m_sp = 0; m_done = 0; m_inc = 0; m_dec = 0;
    m_ku = -1; m_kd = -1;
  endtask

  task automatic model_edge();
    bit tev, sev, lu, ld;
    int old;
    tev = trig && !m_tp;
    sev = set && !m_sp;
    m_tp = trig;
    m_sp = set;
    lu = up && !down;
    ld = down && !up;
    old = m_st;
    m_ku = (old == StSetup && lu) ? m_ku + 1 : -1;
    m_kd = (old == StSetup && ld) ? m_kd + 1 : -1;
    m_done = 0;
    case (old)
      StInit: begin
        if (tev) m_st = StRun;
        else if (sev) begin
          m_st = StSetup;
          for (int i = 0; i < 2; i++) m_fsel[i] = nf[i] - 1;
        end
      end
      StSetup: begin
        if (tev) m_st = StRun;
        else if (sev) for (int i = 0; i < 2; i++) m_fsel[i] = (m_fsel[i] + nf[i] - 1) % nf[i];
      end
      StRun: begin
        if (complete) begin m_st = StInit; m_done = 1; end
        else if (tev) m_st = StPause;
      end
      default: begin
        if (complete) m_st = StInit;
        else if (tev) m_st = StRun;
        else if (sev) begin
          m_st = StSetup;
          for (int i = 0; i < 2; i++) m_fsel[i] = nf[i] - 1;
        end
      end
    endcase
`ifdef CTL_AUTOREPEAT_EN
    m_inc = (m_ku >= 0) && rpt_hit(m_ku) && (m_st == StSetup);
    m_dec = (m_kd >= 0) && rpt_hit(m_kd) && (m_st == StSetup);
`else
    m_inc = lu && (m_st == StSetup);
    m_dec = ld && (m_st == StSetup);
`endif
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    cmp("d3.state", st3, m_st);
    cmp("d3.init_regs", init3, int'(m_st == StInit));
    cmp("d3.count_en", cnt3, int'(m_st == StRun));
    cmp("d3.field_sel", fsel3, m_fsel[0]);
    cmp("d3.done", done3, m_done);
    cmp("d3.inc", inc3, m_inc);
    cmp("d3.dec", dec3, m_dec);
    cmp("d2.state", st2, m_st);
    cmp("d2.init_regs", init2, int'(m_st == StInit));
    cmp("d2.count_en", cnt2, int'(m_st == StRun));
    cmp("d2.field_sel", fsel2, m_fsel[1]);
    cmp("d2.done", done2, m_done);
    cmp("d2.inc", inc2, m_inc);
    cmp("d2.dec", dec2, m_dec);
  endtask

  task automatic step(input bit t, input bit s, input bit u, input bit d, input bit c);
    trig = t; set = s; up = u; down = d; complete = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    bit t, s, u, d, c;
    int st, f3, f2;
    bit done;
  } vec_t;

  vec_t tbl[18];
  int   n_pulse;
  bit   ru, rd;

  initial begin
    // set presses from S_INIT, wraparound, held set, run/complete, re-entry to setup
    tbl[0]  = '{0, 1, 0, 0, 0, StSetup, 2, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, StSetup, 2, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, StSetup, 2, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, StSetup, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, StSetup, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, StSetup, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, StSetup, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, StSetup, 2, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, StSetup, 2, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, StSetup, 2, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, StSetup, 2, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 0, StSetup, 2, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, StSetup, 2, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, StRun,   2, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 1, StInit,  2, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 0, StInit,  2, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 0, StSetup, 2, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 0, StSetup, 2, 1, 0};

    rst_n = 1'b0;
    trig = 0; set = 0; up = 0; down = 0; complete = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].t, tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].c);
      cmp($sformatf("tbl[%0d].state", i), st3, tbl[i].st);
      cmp($sformatf("tbl[%0d].fsel3", i), fsel3, tbl[i].f3);
      cmp($sformatf("tbl[%0d].fsel2", i), fsel2, tbl[i].f2);
      cmp($sformatf("tbl[%0d].done", i), done3, tbl[i].done);
    end

    // Hold up for 80 cycles in S_SETUP.
    n_pulse = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 0, 1, 0, 0);
      n_pulse += int'(inc3);
    end
`ifdef CTL_AUTOREPEAT_EN
    cmp("hold_up_pulses", n_pulse, 4);
`else
    cmp("hold_up_level_cycles", n_pulse, 80);
`endif
    step(0, 0, 0, 0, 0);
    n_pulse = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 1, 1, 0);
      n_pulse += int'(inc3) + int'(dec3);
    end
    cmp("up_down_both_pulses", n_pulse, 0);
    step(0, 0, 0, 0, 0);

    // setup -> run (up held) -> pause -> run -> complete
    step(1, 0, 1, 0, 0);
    cmp("run.count_en", cnt3, 1);
    cmp("run.inc_held_up", inc3, 0);
    step(0, 0, 1, 0, 0);
    cmp("run.inc_held_up2", inc3, 0);
    step(1, 0, 0, 0, 0);
    cmp("pause.count_en", cnt3, 0);
    cmp("pause.state", st3, StPause);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    cmp("resume.state", st3, StRun);
    step(0, 0, 0, 0, 1);
    cmp("complete.init_regs", init3, 1);
    cmp("complete.done", done3, 1);
    step(0, 0, 0, 0, 0);
    cmp("complete.done_one_cycle", done3, 0);

    // complete and trig rising together in S_RUN: complete wins
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    cmp("prio.state", st3, StInit);
    cmp("prio.done", done3, 1);
    step(0, 0, 0, 0, 0);

    // asynchronous reset mid-run
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cmp("prerst.state", st3, StRun);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp("rst.state", st3, StInit);
    cmp("rst.init_regs", init3, 1);
    cmp("rst.count_en", cnt3, 0);
    cmp("rst.field_sel", fsel3, 2);
    cmp("rst.done", done3, 0);
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // random stimulus, level inputs with long holds
    ru = 0; rd = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) ru = ~ru;
      if ($urandom_range(0, 59) == 0) rd = ~rd;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, ru, rd,
           $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
